// File: rtl/drawctrl_fill.sv
// rtl/drawctrl_fill.sv - rectangle fill engine writing packed 8-bit pixels into a 16-bit frame memory
// Optional completion interrupt: define DRAWCTRL_IRQ_EN.
module drawctrl_fill #(
    parameter int HRES     = 640,
    parameter int VRES     = 480,
    parameter int DISPSIZE = 153600
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IO_Address,
    input  logic [31:0] IO_Write_Data,
    input  logic [3:0]  IO_Byte_Enable,
    input  logic        WR,
    output logic [31:0] RDATA,
    output logic [22:0] DMEMADDR,
    output logic [15:0] DMEMDOUT,
    output logic [1:0]  DMEMBE,
    output logic        DMEMREQ,
    input  logic        DMEMACK,
    output logic        IRQ
);
    typedef enum logic [2:0] {IDLE, SETUP, REQ, NEXT, FIN} state_t;

    localparam logic [11:0] HRES12     = 12'(HRES);
    localparam logic [11:0] VRES12     = 12'(VRES);
    localparam logic [22:0] PAGE_WORDS = 23'(DISPSIZE);
    localparam logic [22:0] ROW_WORDS  = 23'(HRES / 2);

    state_t      state, state_nx;
    logic [5:0]  page, l_page;
    logic [9:0]  x0;
    logic [8:0]  y0, y, ye;
    logic [10:0] w;
    logic [9:0]  h;
    logic [7:0]  color, l_color;
    logic [11:0] xs, xe, x, x_nx, x_step;
    logic [22:0] row_base;
    logic        f_empty, done, irqen;
    logic        we, start, ctrl_wr, in_req;
    logic [13:0] idx;
    logic [11:0] x_last, y_last, xe_clip, ye_clip;
    logic        empty;
    logic [1:0]  be_cur;
    logic        unused_bits;

    assign we      = WR & IO_Byte_Enable[0];
    assign idx     = IO_Address[15:2];
    assign ctrl_wr = we && (idx == 14'd4);
    assign start   = ctrl_wr && IO_Write_Data[0] && (state == IDLE);
    assign unused_bits = ^{IO_Address[31:16], IO_Address[1:0], IO_Byte_Enable[3:1],
                           IO_Write_Data[31:26], IO_Write_Data[15:11]};

    // Clip against the frame using the live registers; the result is latched at start
    assign x_last  = {2'b0, x0} + {1'b0, w} - 12'd1;
    assign y_last  = {3'b0, y0} + {2'b0, h} - 12'd1;
    assign xe_clip = (x_last > HRES12 - 12'd1) ? HRES12 - 12'd1 : x_last;
    assign ye_clip = (y_last > VRES12 - 12'd1) ? VRES12 - 12'd1 : y_last;
    assign empty   = (w == 11'd0) || (h == 10'd0) || ({2'b0, x0} >= HRES12) || ({3'b0, y0} >= VRES12);

    always_comb begin
        be_cur = 2'b01;
        x_step = 12'd1;
        if (x[0]) begin
            be_cur = 2'b10;
        end else if (x < xe) begin
            be_cur = 2'b11;
            x_step = 12'd2;
        end
    end
    assign x_nx = x + x_step;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = SETUP;
            SETUP: state_nx = f_empty ? FIN : REQ;
            REQ:   if (DMEMACK) state_nx = NEXT;
            NEXT: begin
                if (x_nx <= xe)   state_nx = REQ;
                else if (y == ye) state_nx = FIN;
                else              state_nx = SETUP;
            end
            FIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            page <= '0; x0 <= '0; y0 <= '0; w <= '0; h <= '0; color <= '0;
            l_page <= '0; l_color <= '0; xs <= '0; xe <= '0; ye <= '0;
            x <= '0; y <= '0; row_base <= '0; f_empty <= 1'b0; done <= 1'b0;
        end else begin
            if (we) begin
                case (idx)
                    14'd0: page <= IO_Write_Data[5:0];
                    14'd1: begin x0 <= IO_Write_Data[9:0]; y0 <= IO_Write_Data[24:16]; end
                    14'd2: begin w <= IO_Write_Data[10:0]; h <= IO_Write_Data[25:16]; end
                    14'd3: color <= IO_Write_Data[7:0];
                    default: ;
                endcase
            end
            // Completion wins over a simultaneous clear
            if (state == FIN)                    done <= 1'b1;
            else if (ctrl_wr && IO_Write_Data[1]) done <= 1'b0;
            if (start) begin
                l_page  <= page;
                l_color <= color;
                xs      <= {2'b0, x0};
                xe      <= xe_clip;
                ye      <= ye_clip[8:0];
                y       <= y0;
                f_empty <= empty;
            end
            if (state == SETUP) begin
                row_base <= {17'b0, l_page} * PAGE_WORDS + {14'b0, y} * ROW_WORDS;
                x        <= xs;
            end
            if (state == NEXT) begin
                x <= x_nx;
                if (state_nx == SETUP) y <= y + 9'd1;
            end
        end
    end

`ifdef DRAWCTRL_IRQ_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            irqen <= 1'b0;
            IRQ   <= 1'b0;
        end else begin
            if (ctrl_wr) irqen <= IO_Write_Data[2];
            IRQ <= done & irqen;
        end
    end
`else
    assign irqen = 1'b0;
    assign IRQ   = 1'b0;
`endif

    // Request outputs are derived from state so reset clears them without a clock
    assign in_req   = (state == REQ);
    assign DMEMREQ  = in_req;
    assign DMEMADDR = in_req ? row_base + {12'b0, x[11:1]} : 23'd0;
    assign DMEMBE   = in_req ? be_cur : 2'b00;
    assign DMEMDOUT = in_req ? {l_color, l_color} : 16'd0;

    always_comb begin
        RDATA = 32'd0;
        case (idx)
            14'd0: RDATA = {26'b0, page};
            14'd1: RDATA = {7'b0, y0, 6'b0, x0};
            14'd2: RDATA = {6'b0, h, 5'b0, w};
            14'd3: RDATA = {24'b0, color};
            14'd4: RDATA = {29'b0, irqen, done, state != IDLE};
            default: RDATA = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_drawctrl_fill.sv
// tb/tb_drawctrl_fill.sv - directed table-driven bench for drawctrl_fill
module tb_drawctrl_fill;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] IO_Address = 32'h10;
    logic [31:0] IO_Write_Data = 32'd0;
    logic [3:0]  IO_Byte_Enable = 4'hF;
    logic        WR = 1'b0;
    logic [31:0] RDATA;
    logic [22:0] DMEMADDR;
    logic [15:0] DMEMDOUT;
    logic [1:0]  DMEMBE;
    logic        DMEMREQ;
    logic        DMEMACK = 1'b0;
    logic        IRQ;

    drawctrl_fill dut (
        .CLK(CLK), .RST_N(RST_N), .IO_Address(IO_Address), .IO_Write_Data(IO_Write_Data),
        .IO_Byte_Enable(IO_Byte_Enable), .WR(WR), .RDATA(RDATA), .DMEMADDR(DMEMADDR),
        .DMEMDOUT(DMEMDOUT), .DMEMBE(DMEMBE), .DMEMREQ(DMEMREQ), .DMEMACK(DMEMACK), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

`ifdef DRAWCTRL_IRQ_EN
    localparam logic IRQ_EXP = 1'b1;
`else
    localparam logic IRQ_EXP = 1'b0;
`endif

    int passed = 0;
    int total  = 0;

    // memory responder: acks ack_delay cycles after a request appears, logs each write
    int          ack_delay = 1;
    int          wait_cnt  = 0;
    int          req_hi    = 0;
    logic        held_bad  = 1'b0;
    logic [22:0] h_addr;
    logic [1:0]  h_be;
    logic [15:0] h_dout;
    logic [22:0] log_addr[$];
    logic [1:0]  log_be[$];
    logic [15:0] log_dout[$];

    always @(negedge CLK) begin
        DMEMACK = 1'b0;
        if (!RST_N || !DMEMREQ) begin
            wait_cnt = 0;
        end else begin
            req_hi++;
            if (wait_cnt == 0) begin
                h_addr = DMEMADDR; h_be = DMEMBE; h_dout = DMEMDOUT;
            end else if (DMEMADDR !== h_addr || DMEMBE !== h_be || DMEMDOUT !== h_dout) begin
                held_bad = 1'b1;
            end
            if (wait_cnt >= ack_delay) begin
                DMEMACK = 1'b1;
                log_addr.push_back(DMEMADDR);
                log_be.push_back(DMEMBE);
                log_dout.push_back(DMEMDOUT);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic bus_write(input int idx, input logic [31:0] data);
        @(negedge CLK);
        IO_Address    = 32'(idx) << 2;
        IO_Write_Data = data;
        WR            = 1'b1;
        @(negedge CLK);
        WR         = 1'b0;
        IO_Address = 32'h10;
    endtask

    task automatic read_reg(input int idx, output logic [31:0] val);
        IO_Address = 32'(idx) << 2;
        #1 val = RDATA;
        IO_Address = 32'h10;
    endtask

    task automatic wait_done(input string name);
        int cnt = 0;
        IO_Address = 32'h10;
        while (RDATA[1] !== 1'b1 && cnt < 2000) begin
            @(negedge CLK);
            cnt++;
        end
        if (cnt >= 2000) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic clear_logs();
        log_addr.delete(); log_be.delete(); log_dout.delete();
    endtask

    typedef struct {
        logic [5:0]  page;
        logic [9:0]  x0;
        logic [8:0]  y0;
        logic [10:0] w;
        logic [9:0]  h;
        logic [7:0]  color;
        int          n;
        logic [22:0] a0, a1, a2;
        logic [1:0]  b0, b1, b2;
    } vec_t;

    vec_t        vt[6];
    logic [31:0] rv;
    logic [22:0] ea;
    logic [1:0]  eb;
    int          busy_cnt;
    int          nreq;

    initial begin
        vt[0] = '{6'd0, 10'd10,  9'd2,   11'd4,  10'd1, 8'h5A, 2, 23'd645,    23'd646, 23'd0, 2'b11, 2'b11, 2'b00};
        vt[1] = '{6'd0, 10'd3,   9'd0,   11'd4,  10'd1, 8'h11, 3, 23'd1,      23'd2,   23'd3, 2'b10, 2'b11, 2'b01};
        vt[2] = '{6'd1, 10'd638, 9'd479, 11'd10, 10'd5, 8'h33, 1, 23'd307199, 23'd0,   23'd0, 2'b11, 2'b00, 2'b00};
        vt[3] = '{6'd0, 10'd20,  9'd5,   11'd0,  10'd3, 8'h44, 0, 23'd0,      23'd0,   23'd0, 2'b00, 2'b00, 2'b00};
        vt[4] = '{6'd0, 10'd5,   9'd1,   11'd1,  10'd2, 8'h80, 2, 23'd322,    23'd642, 23'd0, 2'b10, 2'b10, 2'b00};
        vt[5] = '{6'd0, 10'd640, 9'd0,   11'd4,  10'd1, 8'h77, 0, 23'd0,      23'd0,   23'd0, 2'b00, 2'b00, 2'b00};

        // reset state
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 6; i++) begin
            read_reg(i, rv);
            chk($sformatf("reset_reg%0d", i), rv, 32'd0);
        end
        chk("reset_req", {31'd0, DMEMREQ}, 32'd0);
        chk("reset_addr", {9'd0, DMEMADDR}, 32'd0);
        chk("reset_irq", {31'd0, IRQ}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        bus_write(4, 32'h4);
        for (int v = 0; v < 6; v++) begin
            bus_write(0, {26'd0, vt[v].page});
            bus_write(1, {7'd0, vt[v].y0, 6'd0, vt[v].x0});
            bus_write(2, {6'd0, vt[v].h, 5'd0, vt[v].w});
            bus_write(3, {24'd0, vt[v].color});
            if (v == 0) begin
                read_reg(1, rv);
                chk("readback_xy", rv, 32'h0002_000A);
            end
            clear_logs();
            bus_write(4, 32'h5);
            wait_done($sformatf("v%0d", v));
            chk($sformatf("v%0d_count", v), 32'(log_addr.size()), 32'(vt[v].n));
            for (int k = 0; k < vt[v].n && k < log_addr.size(); k++) begin
                ea = (k == 0) ? vt[v].a0 : (k == 1) ? vt[v].a1 : vt[v].a2;
                eb = (k == 0) ? vt[v].b0 : (k == 1) ? vt[v].b1 : vt[v].b2;
                chk($sformatf("v%0d_addr%0d", v, k), {9'd0, log_addr[k]}, {9'd0, ea});
                chk($sformatf("v%0d_be%0d", v, k), {30'd0, log_be[k]}, {30'd0, eb});
                chk($sformatf("v%0d_data%0d", v, k), {16'd0, log_dout[k]}, {16'd0, vt[v].color, vt[v].color});
            end
            @(negedge CLK);
            read_reg(4, rv);
            chk($sformatf("v%0d_status", v), rv, {29'd0, IRQ_EXP, 2'b10});
            chk($sformatf("v%0d_irq", v), {31'd0, IRQ}, {31'd0, IRQ_EXP});
            bus_write(4, 32'h6);
            @(negedge CLK);
            read_reg(4, rv);
            chk($sformatf("v%0d_clr", v), rv, {29'd0, IRQ_EXP, 2'b00});
            chk($sformatf("v%0d_irq_clr", v), {31'd0, IRQ}, 32'd0);
        end
        chk("unmapped", (read_unmapped()), 32'd0);

        // empty region: busy for exactly two cycles, no request
        bus_write(2, 32'h0001_0000);
        req_hi   = 0;
        busy_cnt = 0;
        bus_write(4, 32'h1);
        for (int i = 0; i < 10; i++) begin
            #1 if (RDATA[0]) busy_cnt++;
            @(negedge CLK);
        end
        chk("empty_busy_cycles", 32'(busy_cnt), 32'd2);
        chk("empty_no_req", 32'(req_hi), 32'd0);
        read_reg(4, rv);
        chk("empty_done", {30'd0, rv[1:0]}, 32'd2);
        bus_write(4, 32'h2);

        // slow ack: outputs held, register writes and start during busy ignored
        ack_delay = 5;
        held_bad  = 1'b0;
        bus_write(0, 32'd0);
        bus_write(1, 32'd0);
        bus_write(2, 32'h0001_0004);
        bus_write(3, 32'hC3);
        clear_logs();
        bus_write(4, 32'h1);
        bus_write(1, 32'd100);
        bus_write(4, 32'h1);
        wait_done("slow");
        repeat (20) @(negedge CLK);
        chk("slow_count", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() >= 2) begin
            chk("slow_addr0", {9'd0, log_addr[0]}, 32'd0);
            chk("slow_addr1", {9'd0, log_addr[1]}, 32'd1);
            chk("slow_be1", {30'd0, log_be[1]}, 32'd3);
        end
        chk("slow_held", {31'd0, held_bad}, 32'd0);
        bus_write(4, 32'h2);

        // reset in the middle of a row
        ack_delay = 8;
        bus_write(2, 32'h0001_0010);
        bus_write(4, 32'h1);
        nreq = 0;
        while (DMEMREQ !== 1'b1 && nreq < 100) begin
            @(negedge CLK);
            nreq++;
        end
        chk("rst_req_seen", {31'd0, DMEMREQ}, 32'd1);
        #1 RST_N = 1'b0;
        #1;
        chk("rst_req_async", {31'd0, DMEMREQ}, 32'd0);
        chk("rst_be_async", {30'd0, DMEMBE}, 32'd0);
        chk("rst_addr_async", {9'd0, DMEMADDR}, 32'd0);
        @(negedge CLK);
        RST_N  = 1'b1;
        req_hi = 0;
        repeat (20) @(negedge CLK);
        chk("rst_no_resume", 32'(req_hi), 32'd0);
        read_reg(4, rv);
        chk("rst_status", rv, 32'd0);
        read_reg(2, rv);
        chk("rst_reg_w", rv, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    function automatic logic [31:0] read_unmapped();
        return (IO_Address == 32'h10) ? 32'd0 : 32'hFFFF_FFFF;
    endfunction
endmodule
